csr_priv_access_arbiter: RTL

//  Shares one privileged CSR/register file between two requesters: port 0 is the core, port 1 is debug.

---
 rtl/csr_priv_pkg.sv | 27 ++
 rtl/csr_priv_checker.sv | 37 +++
 rtl/csr_priv_access_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/csr_priv_pkg.sv
// Shared types and constants for the privileged CSR access arbiter and any
// other block that reuses the privilege checker.
package csr_priv_pkg;

    // Privilege levels; encoding 2'b10 is reserved and never matches MACHINE.
    typedef enum logic [1:0] {
        USER         = 2'b00,
        SUPERVISOR   = 2'b01,
        MACHINE_PRIV = 2'b11
    } priv_t;

    // Arbiter transaction states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ACCESS = 3'd2,
        DENY   = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    // Default protected window and the named registers that live inside it.
    localparam logic [11:0] DEF_PROT_BASE  = 12'h060;
    localparam logic [11:0] DEF_PROT_LIMIT = 12'h06F;
    localparam logic [11:0] STACK_REG      = 12'h064;
    localparam logic [11:0] PC_REG         = 12'h068;

endpackage

// File: rtl/csr_priv_checker.sv
// Combinational privilege check for one CSR access.
// Ports:
//   read_i / write_i : access strobes (exactly one must be set)
//   priv_i           : privilege level of the requester
//   addr_i           : CSR address
//   allow_o          : 1 = access may proceed, 0 = deny
module csr_priv_checker
    import csr_priv_pkg::*;
#(
    parameter int                 ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]  PROT_BASE  = ADDR_W'(DEF_PROT_BASE),
    parameter logic [ADDR_W-1:0]  PROT_LIMIT = ADDR_W'(DEF_PROT_LIMIT)
) (
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        priv_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              allow_o
);

    logic in_window_s;
    logic bad_strobe_s;
    logic low_priv_s;

    // Allow/deny decision: malformed strobes or a non-MACHINE access to the window.
    always_comb begin
        in_window_s  = (addr_i >= PROT_BASE) && (addr_i <= PROT_LIMIT);
        bad_strobe_s = (read_i == write_i);
        low_priv_s   = (priv_t'(priv_i) != MACHINE_PRIV);
        if (bad_strobe_s || (in_window_s && low_priv_s)) begin
            allow_o = 1'b0;
        end else begin
            allow_o = 1'b1;
        end
    end

endmodule

// File: rtl/csr_priv_access_arbiter.sv
// Two-port round-robin arbiter in front of a privileged CSR file.
// Port 0 is the core, port 1 is debug. Every access is privilege-checked;
// denied accesses never touch the register file, they answer with a fault,
// a one-cycle viol_irq pulse and a saturating viol_cnt increment.
// Allowed and denied accesses both take IDLE->CHECK->ACCESS/DENY->RESP so
// the response latency does not leak the decision.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   req/write/read/priv_state/address/wdata : per-requester request fields
//   ack/fault/rdata              : per-requester response (valid in RESP)
//   rf_en/rf_we/rf_addr/rf_wdata : register-file access (ACCESS only)
//   rf_rdata                     : register-file read data, valid in RESP
//   viol_irq/viol_cnt            : violation pulse and saturating counter
module csr_priv_access_arbiter
    import csr_priv_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]  PROT_BASE  = ADDR_W'(DEF_PROT_BASE),
    parameter logic [ADDR_W-1:0]  PROT_LIMIT = ADDR_W'(DEF_PROT_LIMIT),
    parameter int                 CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0]             write,
    input  logic [1:0]             read,
    input  logic [1:0][1:0]        priv_state,
    input  logic [1:0][ADDR_W-1:0] address,
    input  logic [1:0][DATA_W-1:0] wdata,
    output logic [1:0]             ack,
    output logic [1:0]             fault,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rf_en,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_addr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [DATA_W-1:0]      rf_rdata,
    output logic                   viol_irq,
    output logic [CNT_W-1:0]       viol_cnt
);

    arb_state_t        state_q,  state_d;
    logic              rr_q,     rr_d;
    logic              win_q,    win_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic [1:0]        priv_q,   priv_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              denied_q, denied_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              allow_s;

    // The check only ever sees the latched fields of the granted requester.
    csr_priv_checker #(
        .ADDR_W     (ADDR_W),
        .PROT_BASE  (PROT_BASE),
        .PROT_LIMIT (PROT_LIMIT)
    ) u_checker (
        .read_i  (rd_q),
        .write_i (wr_q),
        .priv_i  (priv_q),
        .addr_i  (addr_q),
        .allow_o (allow_s)
    );

    // State, arbitration pointer, request latch and violation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            win_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            priv_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            denied_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            win_q    <= win_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            priv_q   <= priv_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            denied_q <= denied_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: grant/latch in IDLE, decide in CHECK, rotate after RESP.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        win_d    = win_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        priv_d   = priv_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        denied_d = denied_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // Favoured port wins if requesting, otherwise the lone requester.
                    if (req[rr_q]) begin
                        win_d = rr_q;
                    end else begin
                        win_d = ~rr_q;
                    end
                    rd_d    = read[win_d];
                    wr_d    = write[win_d];
                    priv_d  = priv_state[win_d];
                    addr_d  = address[win_d];
                    wdata_d = wdata[win_d];
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                denied_d = ~allow_s;
                if (allow_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = DENY;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            DENY: begin
                // Count lands as RESP starts, so it is visible alongside viol_irq.
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rr_d    = ~win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state; everything idles at zero.
    always_comb begin
        ack      = 2'b00;
        fault    = 2'b00;
        rdata    = '0;
        rf_en    = 1'b0;
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        viol_irq = 1'b0;
        case (state_q)
            ACCESS: begin
                rf_en    = 1'b1;
                rf_we    = wr_q;
                rf_addr  = addr_q;
                rf_wdata = wdata_q;
            end
            RESP: begin
                ack[win_q]   = 1'b1;
                fault[win_q] = denied_q;
                viol_irq     = denied_q;
                // Allowed accesses have exactly one strobe, so rd_q here means a pure read.
                if (rd_q && !denied_q) begin
                    rdata = rf_rdata;
                end else begin
                    rdata = '0;
                end
            end
            default: begin
                ack = 2'b00;
            end
        endcase
    end

    assign viol_cnt = cnt_q;

endmodule
